// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// No logic: opcodes, FSM state codes, ALU source/op codes, control vector.
// No flow control; constants only.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Raw per-state control word; FETCH's PC/IR loads are later gated by mem_ready.
    typedef struct packed {
        logic       pc_write;
        logic       banch;
        logic       jump;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Maps the FSM state code to the datapath control vector.
// Purely combinational, zero latency.
// No flow control; unused state codes decode to all-zero controls.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    // Every field defaults to 0; each state raises only what it needs.
    always_comb begin
        ctrl_o = '0;
        case (state_t'(state_i))
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMMSH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.banch     = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.jump = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait timeout and retired counter.
// Controls are combinational from state (FETCH loads gated by mem_ready).
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; aborts to FETCH after TIMEOUT waits.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             Banch,
    output logic             jump,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    // Counter holds 0..TIMEOUT-1; the TIMEOUT-th consecutive wait cycle aborts.
    localparam int unsigned WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               waiting, timeout, retire;
    ctrl_t              ctrl;

    // funct selects the ALU operation downstream; it does not steer the sequence.
    logic unused_funct;
    assign unused_funct = ^funct;

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout = (TIMEOUT != 0) && waiting && !mem_ready &&
                     (wait_q == WAIT_W'(TO_LAST));

    // Next state, event pulses, retire strobe and wait counter update.
    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        bus_err = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)     state_d = S_DECODE;
                else if (timeout)  bus_err = 1'b1;
                else               state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)     state_d = S_MEMWB;
                else if (timeout)  bus_err = 1'b1;
                else               state_d = S_MEMRD;
            end
            S_MEMWB:  retire = 1'b1;
            S_MEMWR: begin
                if (mem_ready)     retire  = 1'b1;
                else if (timeout)  bus_err = 1'b1;
                else               state_d = S_MEMWR;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  retire  = 1'b1;
            S_BRANCH: retire  = 1'b1;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: retire  = 1'b1;
            S_JUMP:   retire  = 1'b1;
            default:  state_d = S_FETCH;
        endcase

        // Only a stall (same state, no abort) keeps counting; anything else clears.
        wait_d = '0;
        if (waiting && !mem_ready && !timeout) begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
        end

        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    // State, wait counter and retired counter registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // PC and IR load only when the fetch actually completes.
    assign PCWrite  = ctrl.pc_write & mem_ready;
    assign IRWrite  = ctrl.ir_write & mem_ready;
    assign Banch    = ctrl.banch;
    assign jump     = ctrl.jump;
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign retired  = retired_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (CNT_W=4, TIMEOUT=4): per-cycle vector table
// plus hand sequences for async reset mid-access and retired counter wrap.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mc_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, Banch, jump, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, illegal, bus_err;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] retired;
    logic [3:0] state;

    mc_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .Banch(Banch), .jump(jump),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal(illegal), .bus_err(bus_err), .retired(retired), .state(state)
    );

    always #5 CLK = ~CLK;

    // Control word: {PCWrite,Banch,jump,IorD,MemRead,MemWrite,IRWrite,RegDst,
    //                MemtoReg,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],illegal,bus_err}
    localparam logic [16:0] C_FETCH_W   = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_0_0;
    localparam logic [16:0] C_FETCH_R   = 17'b1_0_0_0_1_0_1_0_0_0_0_01_00_0_0;
    localparam logic [16:0] C_FETCH_TO  = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_0_1;
    localparam logic [16:0] C_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam logic [16:0] C_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_1_0;
    localparam logic [16:0] C_MEMADR    = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [16:0] C_MEMRD     = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [16:0] C_MEMRD_TO  = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_0_1;
    localparam logic [16:0] C_MEMWB     = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_0_0;
    localparam logic [16:0] C_MEMWR     = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_0_0;
    localparam logic [16:0] C_EXEC      = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [16:0] C_ALUWB     = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_0_0;
    localparam logic [16:0] C_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_0_0;
    localparam logic [16:0] C_ADDIEX    = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [16:0] C_ADDIWB    = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_0_0;
    localparam logic [16:0] C_JUMP      = 17'b0_0_1_0_0_0_0_0_0_0_0_00_00_0_0;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [3:0]  ret;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [16:0] ctl_now();
        return {PCWrite, Banch, jump, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, bus_err};
    endfunction

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [16:0] ctl, input logic [3:0] ret);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [3:0] st,
                         input logic [16:0] ctl, input logic [3:0] ret);
        n_checks += 3;
        if (state !== st) begin
            n_fail++;
            $display("FAIL %s[%0d] state: got %0d expected %0d", nm, idx, state, st);
        end
        if (ctl_now() !== ctl) begin
            n_fail++;
            $display("FAIL %s[%0d] ctl: got %b expected %b", nm, idx, ctl_now(), ctl);
        end
        if (retired !== ret) begin
            n_fail++;
            $display("FAIL %s[%0d] retired: got %0d expected %0d", nm, idx, retired, ret);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = RT; funct = 6'h20; mem_ready = 1'b0;

        // lw, zero wait
        add(LW, 1, 0, C_FETCH_R, 0); add(LW, 1, 1, C_DECODE, 0);
        add(LW, 1, 2, C_MEMADR, 0);  add(LW, 1, 3, C_MEMRD, 0);
        add(LW, 1, 4, C_MEMWB, 0);
        // beq
        add(BQ, 1, 0, C_FETCH_R, 1); add(BQ, 1, 1, C_DECODE, 1);
        add(BQ, 1, 8, C_BRANCH, 1);
        // j
        add(JJ, 1, 0, C_FETCH_R, 2); add(JJ, 1, 1, C_DECODE, 2);
        add(JJ, 1, 11, C_JUMP, 2);
        // R-type
        add(RT, 1, 0, C_FETCH_R, 3); add(RT, 1, 1, C_DECODE, 3);
        add(RT, 1, 6, C_EXEC, 3);    add(RT, 1, 7, C_ALUWB, 3);
        // addi
        add(AI, 1, 0, C_FETCH_R, 4); add(AI, 1, 1, C_DECODE, 4);
        add(AI, 1, 9, C_ADDIEX, 4);  add(AI, 1, 10, C_ADDIWB, 4);
        // sw with 3 wait cycles in MEMWR
        add(SW, 1, 0, C_FETCH_R, 5); add(SW, 1, 1, C_DECODE, 5);
        add(SW, 1, 2, C_MEMADR, 5);  add(SW, 0, 5, C_MEMWR, 5);
        add(SW, 0, 5, C_MEMWR, 5);   add(SW, 0, 5, C_MEMWR, 5);
        add(SW, 1, 5, C_MEMWR, 5);
        // illegal opcode after one fetch wait
        add(BAD, 0, 0, C_FETCH_W, 6); add(BAD, 1, 0, C_FETCH_R, 6);
        add(BAD, 1, 1, C_DEC_ILL, 6);
        // lw aborted by timeout in MEMRD
        add(LW, 1, 0, C_FETCH_R, 6); add(LW, 1, 1, C_DECODE, 6);
        add(LW, 1, 2, C_MEMADR, 6);  add(LW, 0, 3, C_MEMRD, 6);
        add(LW, 0, 3, C_MEMRD, 6);   add(LW, 0, 3, C_MEMRD, 6);
        add(LW, 0, 3, C_MEMRD_TO, 6);
        // lw completing on the timeout cycle
        add(LW, 1, 0, C_FETCH_R, 6); add(LW, 1, 1, C_DECODE, 6);
        add(LW, 1, 2, C_MEMADR, 6);  add(LW, 0, 3, C_MEMRD, 6);
        add(LW, 0, 3, C_MEMRD, 6);   add(LW, 0, 3, C_MEMRD, 6);
        add(LW, 1, 3, C_MEMRD, 6);   add(LW, 1, 4, C_MEMWB, 6);
        // fetch timeout then restarted fetch of an R-type
        add(RT, 0, 0, C_FETCH_W, 7); add(RT, 0, 0, C_FETCH_W, 7);
        add(RT, 0, 0, C_FETCH_W, 7); add(RT, 0, 0, C_FETCH_TO, 7);
        add(RT, 1, 0, C_FETCH_R, 7); add(RT, 1, 1, C_DECODE, 7);
        add(RT, 1, 6, C_EXEC, 7);    add(RT, 1, 7, C_ALUWB, 7);
        // next lw starts; continues in the reset sequence
        add(LW, 1, 0, C_FETCH_R, 8);

        // Reset state
        repeat (2) @(negedge CLK);
        #1 check("reset", 0, 4'd0, C_FETCH_W, 4'd0);
        @(negedge CLK);
        reset = 1'b0;

        foreach (vecs[i]) begin
            opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            #1 check("vec", i, vecs[i].st, vecs[i].ctl, vecs[i].ret);
            @(negedge CLK);
        end

        // lw in flight: DECODE -> MEMADR -> MEMRD, then async reset mid-access
        opcode = LW; mem_ready = 1'b1;
        #1 check("rst_seq", 0, 4'd1, C_DECODE, 4'd8);
        @(negedge CLK);
        #1 check("rst_seq", 1, 4'd2, C_MEMADR, 4'd8);
        @(negedge CLK);
        mem_ready = 1'b0;
        #1 check("rst_seq", 2, 4'd3, C_MEMRD, 4'd8);
        #1 reset = 1'b1;
        #1 check("rst_seq", 3, 4'd0, C_FETCH_W, 4'd0);
        @(negedge CLK);
        reset = 1'b0;

        // 16 R-type instructions: retired wraps 15 -> 0
        opcode = RT; mem_ready = 1'b1;
        repeat (15 * 4) @(negedge CLK);
        #1 check("wrap", 0, 4'd0, C_FETCH_R, 4'd15);
        repeat (3) @(negedge CLK);
        #1 check("wrap", 1, 4'd7, C_ALUWB, 4'd15);
        @(negedge CLK);
        #1 check("wrap", 2, 4'd0, C_FETCH_R, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
